// File: rtl/router_src_arbiter_pkg.sv
// Shared router definitions: byte width, header field positions,
// and the source arbiter state encoding.
package router_src_arbiter_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB  = 2;
   localparam int LEN_MSB  = 7;
   localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      PARITY,
      GAP
   } arb_state_t;

endpackage

// File: rtl/router_src_arbiter_if.sv
// Source-side and router-side signals of the packet arbiter.
// slave = arbiter view, master = sources/router view.
interface router_src_arbiter_if #(
   parameter int NUM_SRC = 4
);
   import router_src_arbiter_pkg::*;

   logic [NUM_SRC-1:0]        src_pkt_valid;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      busy;
   logic                      pkt_valid;
   logic [DATA_W-1:0]         data_in;
   logic [NUM_SRC-1:0]        grant;
   logic                      arb_busy;
   logic                      len_err;

   modport slave (
      input  src_pkt_valid, src_data, busy,
      output src_ready, pkt_valid, data_in,
      output grant, arb_busy, len_err
   );

   modport master (
      output src_pkt_valid, src_data, busy,
      input  src_ready, pkt_valid, data_in,
      input  grant, arb_busy, len_err
   );

endinterface

// File: rtl/router_src_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after 'last',
// wrapping; one-hot grant plus its index.
module router_src_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = last;
      any = 1'b0;
      j   = 0;
      for (int k = 1; k <= N; k++) begin
         j = int'(last) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/router_src_arbiter.sv
// Packet round-robin arbiter: NUM_SRC sources onto the router input.
// Grant held header..parity, then a fixed gap before rearbitration.
module router_src_arbiter
   import router_src_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int GAP_CYC = 2
) (
   input logic clock,
   input logic resetn,
   router_src_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_SRC);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_SRC - 1);

   arb_state_t state, state_n;

   logic [NUM_SRC-1:0] grant_q, pick_gnt;
   logic [IW-1:0]      last, pick_idx;
   logic               pick_any;
   logic [LEN_W-1:0]   exp_len, pay_cnt;
   logic               pay_ovf, hdr_seen;
   logic [GW-1:0]      gap_cnt, gap_dec;
   logic               cur_valid;
   logic [DATA_W-1:0]  cur_data;
   logic               acc_x, acc_p;

   router_src_arbiter_rr_pick #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_pick (
      .req  (bus.src_pkt_valid),
      .last (last),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign cur_valid = bus.src_pkt_valid[last];
   assign cur_data  = bus.src_data[last*DATA_W +: DATA_W];
   assign gap_dec   = (gap_cnt != '0) ? gap_cnt - GW'(1) : '0;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // A valid drop in XFER is not a beat; the parity byte is taken in PARITY.
   always_comb begin
      state_n = state;
      acc_x   = 1'b0;
      acc_p   = 1'b0;
      unique case (state)
         IDLE:   if (!bus.busy && pick_any) state_n = XFER;
         XFER:   if (!cur_valid) state_n = PARITY;
                 else acc_x = !bus.busy;
         PARITY: if (!bus.busy) begin
                    acc_p   = 1'b1;
                    state_n = GAP;
                 end
         GAP:    if (gap_dec == '0 && !bus.busy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         grant_q  <= '0;
         last     <= LAST_RST;
         exp_len  <= '0;
         pay_cnt  <= '0;
         pay_ovf  <= 1'b0;
         hdr_seen <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         if (state == IDLE && state_n == XFER) begin
            grant_q  <= pick_gnt;
            last     <= pick_idx;
            exp_len  <= '0;
            pay_cnt  <= '0;
            pay_ovf  <= 1'b0;
            hdr_seen <= 1'b0;
         end
         if (acc_x) begin
            if (!hdr_seen) begin
               hdr_seen <= 1'b1;
               exp_len  <= cur_data[LEN_MSB:LEN_LSB];
            end else if (pay_cnt == '1) begin
               pay_ovf <= 1'b1;
            end else begin
               pay_cnt <= pay_cnt + LEN_W'(1);
            end
         end
         if (acc_p) begin
            grant_q <= '0;
            gap_cnt <= GW'(GAP_CYC);
         end else if (state == GAP) begin
            gap_cnt <= gap_dec;
         end
      end
   end

   assign bus.src_ready = grant_q & {NUM_SRC{acc_x | acc_p}};
   assign bus.pkt_valid = (state == XFER) && cur_valid;
   assign bus.data_in   = (state == XFER || state == PARITY) ? cur_data : '0;
   assign bus.grant     = grant_q;
   assign bus.arb_busy  = (state != IDLE);
   assign bus.len_err   = acc_p && (pay_ovf || pay_cnt != exp_len);

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: vector table, directed corner cases,
// and random traffic against a packet-level scoreboard.
module tb_router_src_arbiter;

   localparam int N   = 4;
   localparam int GAP = 2;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   router_src_arbiter_if #(.NUM_SRC(N)) bus();

   router_src_arbiter #(
      .NUM_SRC (N),
      .GAP_CYC (GAP)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        b;
      logic [18:0] e;
   } vec_t;

   vec_t tv[$];
   int n_chk  = 0;
   int n_pass = 0;

   logic [8:0] sq[N][$];
   logic [8:0] eq[N][$];
   bit         ee[N][$];
   int         win_q[$];
   int         mlast, cyc, cyc_p;
   logic [N-1:0] pg, preq, vld, s_rdy;
   logic       s_pv, s_ab;
   logic [7:0] s_din;
   bit         busy_force, rand_busy;
   logic       pv0;
   logic [7:0] d0;

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic vec_t vec(logic v, logic [7:0] d, logic b,
                                logic r, logic pv, logic [7:0] din,
                                logic g, logic le, logic ab);
      vec_t t;
      t.v = v;
      t.d = d;
      t.b = b;
      t.e = {3'b0, r, pv, din, 3'b0, g, le, ab};
      return t;
   endfunction

   function automatic int rr(logic [N-1:0] req, int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic int idx_of(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic add_pkt(input int s, input int len, input int npay);
      logic [7:0] b, par;
      b   = {6'(len), 2'($urandom_range(0, 3))};
      par = b;
      sq[s].push_back({1'b1, b});
      eq[s].push_back({1'b1, b});
      for (int k = 0; k < npay; k++) begin
         b   = 8'($urandom);
         par = par ^ b;
         sq[s].push_back({1'b1, b});
         eq[s].push_back({1'b1, b});
      end
      sq[s].push_back({1'b0, par});
      eq[s].push_back({1'b0, par});
      ee[s].push_back(npay != len || npay > 63);
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) begin
         sq[i].delete();
         eq[i].delete();
         ee[i].delete();
      end
      bus.src_pkt_valid = '0;
      bus.src_data      = '0;
      bus.busy          = 1'b0;
      busy_force = 1'b0;
      rand_busy  = 1'b0;
      mlast = N - 1;
      pg    = '0;
      preq  = '0;
      cyc_p = -100;
      s_ab  = 1'b0;
      win_q.delete();
   endtask

   task automatic do_reset();
      flush();
      resetn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk({bus.grant, bus.src_ready, bus.pkt_valid, bus.data_in,
           bus.arb_busy, bus.len_err} == '0, "reset_outputs",
          {bus.grant, bus.src_ready, bus.pkt_valid, bus.data_in}, 0);
      resetn = 1'b1;
   endtask

   task automatic cycle();
      logic [N*8-1:0] dat;
      logic [N-1:0]   exp_r;
      logic [8:0]     eb;
      bit             x;
      int             w, e, r;
      @(negedge clock);
      dat = '0;
      vld = '0;
      for (int i = 0; i < N; i++)
         if (sq[i].size() > 0) begin
            vld[i]         = sq[i][0][8];
            dat[i*8 +: 8]  = sq[i][0][7:0];
         end
      bus.src_pkt_valid = vld;
      bus.src_data      = dat;
      bus.busy = busy_force | (rand_busy && $urandom_range(0, 3) == 0);
      #1;
      s_rdy = bus.src_ready;
      s_pv  = bus.pkt_valid;
      s_din = bus.data_in;
      s_ab  = bus.arb_busy;
      chk($onehot0(bus.grant), "grant_onehot", bus.grant, 0);
      if (bus.grant != '0 && pg == '0) begin
         w = idx_of(bus.grant);
         e = rr(preq, mlast);
         chk(w == e, "rr_winner", w, e);
         chk(cyc - cyc_p >= GAP + 2, "pkt_spacing", cyc - cyc_p, GAP + 2);
         win_q.push_back(w);
         mlast = (e >= 0) ? e : w;
      end
      if (s_rdy != '0) begin
         r     = mlast;
         exp_r = N'(1) << mlast;
         chk(s_rdy == exp_r && !bus.busy, "ready_qual", s_rdy, exp_r);
         if (eq[r].size() == 0) begin
            chk(1'b0, "extra_beat", r, 0);
         end else begin
            eb = eq[r].pop_front();
            chk({s_pv, s_din} == eb, "beat", {s_pv, s_din}, eb);
            if (!eb[8]) begin
               x = (ee[r].size() > 0) ? ee[r].pop_front() : 1'b0;
               chk(bus.len_err == x, "len_err", bus.len_err, x);
               cyc_p = cyc;
            end
         end
      end else if (bus.len_err) begin
         chk(1'b0, "len_err_stray", 1, 0);
      end
      pg   = bus.grant;
      preq = vld;
      @(posedge clock);
      for (int i = 0; i < N; i++)
         if (s_rdy[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      cyc++;
   endtask

   task automatic drain(input int max);
      int k;
      bit pend;
      k = 0;
      do begin
         cycle();
         k++;
         pend = s_ab;
         for (int i = 0; i < N; i++) if (sq[i].size() > 0) pend = 1'b1;
      end while (pend && k < max);
      chk(!pend, "drain", k, max);
   endtask

   initial begin
      cyc = 0;
      // v  d      b | rdy pv din    g  le ab
      tv.push_back(vec(1, 8'h0C, 0, 0, 0, 8'h00, 0, 0, 0));
      tv.push_back(vec(1, 8'h0C, 0, 1, 1, 8'h0C, 1, 0, 1));
      tv.push_back(vec(1, 8'hA1, 0, 1, 1, 8'hA1, 1, 0, 1));
      tv.push_back(vec(1, 8'hA2, 0, 1, 1, 8'hA2, 1, 0, 1));
      tv.push_back(vec(1, 8'hA3, 0, 1, 1, 8'hA3, 1, 0, 1));
      tv.push_back(vec(0, 8'h5A, 0, 0, 0, 8'h5A, 1, 0, 1));
      tv.push_back(vec(0, 8'h5A, 0, 1, 0, 8'h5A, 1, 0, 1));
      tv.push_back(vec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
      tv.push_back(vec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
      tv.push_back(vec(1, 8'h10, 1, 0, 0, 8'h00, 0, 0, 0));
      tv.push_back(vec(1, 8'h10, 1, 0, 0, 8'h00, 0, 0, 0));
      tv.push_back(vec(1, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0));
      tv.push_back(vec(1, 8'h10, 0, 1, 1, 8'h10, 1, 0, 1));
      tv.push_back(vec(1, 8'hB1, 0, 1, 1, 8'hB1, 1, 0, 1));
      tv.push_back(vec(1, 8'hB2, 0, 1, 1, 8'hB2, 1, 0, 1));
      tv.push_back(vec(0, 8'h77, 0, 0, 0, 8'h77, 1, 0, 1));
      tv.push_back(vec(0, 8'h77, 1, 0, 0, 8'h77, 1, 0, 1));
      tv.push_back(vec(0, 8'h77, 0, 1, 0, 8'h77, 1, 1, 1));
      tv.push_back(vec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
      tv.push_back(vec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
      tv.push_back(vec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));

      do_reset();
      for (int k = 0; k < tv.size(); k++) begin
         @(negedge clock);
         bus.src_pkt_valid = {3'b0, tv[k].v};
         bus.src_data      = {24'h0, tv[k].d};
         bus.busy          = tv[k].b;
         #1;
         chk({bus.src_ready, bus.pkt_valid, bus.data_in, bus.grant,
              bus.len_err, bus.arb_busy} == tv[k].e, $sformatf("vec%0d", k),
             {bus.src_ready, bus.pkt_valid, bus.data_in, bus.grant,
              bus.len_err, bus.arb_busy}, tv[k].e);
      end

      // three sources requesting together, source 0 twice
      do_reset();
      add_pkt(0, 2, 2);
      add_pkt(0, 1, 1);
      add_pkt(1, 3, 3);
      add_pkt(2, 0, 0);
      drain(300);
      chk(win_q.size() == 4 && win_q[0] == 0 && win_q[1] == 1 &&
          win_q[2] == 2 && win_q[3] == 0, "rr_order", win_q.size(), 4);

      // busy held four cycles mid-payload
      do_reset();
      add_pkt(0, 5, 5);
      for (int k = 0; k < 20 && eq[0].size() > 4; k++) cycle();
      busy_force = 1'b1;
      cycle();
      pv0 = s_pv;
      d0  = s_din;
      chk(s_pv && s_rdy == '0, "busy_hold_first", {s_pv, s_rdy}, 9'h100);
      repeat (3) begin
         cycle();
         chk({s_pv, s_din, s_rdy} == {pv0, d0, 4'b0}, "busy_hold",
             {s_pv, s_din, s_rdy}, {pv0, d0, 4'b0});
      end
      busy_force = 1'b0;
      drain(100);

      // payload counter at and past saturation
      do_reset();
      add_pkt(1, 63, 63);
      add_pkt(1, 63, 65);
      add_pkt(3, 4, 2);
      drain(600);

      // reset in the middle of a source 2 packet
      do_reset();
      add_pkt(2, 5, 5);
      for (int k = 0; k < 20 && eq[2].size() > 5; k++) cycle();
      #2 resetn = 1'b0;
      #1;
      chk({bus.grant, bus.src_ready, bus.pkt_valid, bus.data_in,
           bus.arb_busy, bus.len_err} == '0, "async_reset",
          {bus.grant, bus.src_ready, bus.pkt_valid, bus.data_in}, 0);
      flush();
      @(negedge clock);
      #1 resetn = 1'b1;
      add_pkt(0, 1, 1);
      add_pkt(2, 1, 1);
      drain(100);
      chk(win_q.size() > 0 && win_q[0] == 0, "post_reset_winner",
          (win_q.size() > 0) ? win_q[0] : -1, 0);

      // random traffic with random busy
      do_reset();
      rand_busy = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         for (int s = 0; s < N; s++)
            if (sq[s].size() == 0 && $urandom_range(0, 3) == 0) begin
               int np, ln;
               np = $urandom_range(0, 6);
               ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : np;
               add_pkt(s, ln, np);
            end
         cycle();
      end
      rand_busy = 1'b0;
      drain(500);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
